// File: rtl/led_frame_scanner_pkg.sv
// Shared definitions for the LED frame scanner: matrix-controller mode codes,
// scan FSM state type and slot timing helpers. Optional macro: LED_SCAN_BLANK_EN.
package led_frame_scanner_pkg;

    localparam logic [7:0] MODE_IDLE   = 8'h00;
    localparam logic [7:0] MODE_RS_PIC = 8'h03;

    // Length of the anti-ghosting blank slot that may follow each row slot
    localparam int BLANK_CYCLES = 4;

`ifdef LED_SCAN_BLANK_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DWELL = 3'd2,
        ST_BLANK = 3'd3
    } scan_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DWELL = 3'd2
    } scan_state_e;
`endif

    function automatic int calc_row_dwell(input int freq_hz, input int refresh_hz, input int rows);
        return freq_hz / (refresh_hz * rows);
    endfunction

endpackage

// File: rtl/led_frame_scanner_bank.sv
// Double-buffered frame store: writes always target the back bank, the front
// bank is read combinationally, and a swap strobe exchanges the two roles.
module led_frame_bank #(
    parameter int p_row_num    = 8,
    parameter int p_column_num = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [$clog2(p_row_num)-1:0] i_wr_row,
    input  logic [p_column_num-1:0]      i_wr_data,
    input  logic                         i_swap,
    input  logic [$clog2(p_row_num)-1:0] i_rd_row,
    output logic [p_column_num-1:0]      o_rd_data
);

    logic [p_column_num-1:0] r_bank [2][p_row_num];
    logic                    r_front_sel;
    logic                    w_wr_ok;

    // Out-of-range rows are dropped (only reachable for non power-of-two row counts)
    assign w_wr_ok = i_wr_en && (int'(i_wr_row) < p_row_num);

    // Bank storage and front selector; the write uses the back bank as seen before any swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < p_row_num; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
            r_front_sel <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_bank[~r_front_sel][i_wr_row] <= i_wr_data;
            end
            if (i_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    assign o_rd_data = r_bank[r_front_sel][i_rd_row];

endmodule

// File: rtl/led_frame_scanner.sv
// Row-scan instruction source for the LED matrix controller, fed from a
// double-buffered frame. Optional macro: LED_SCAN_BLANK_EN adds a blank slot per row.
module led_frame_scanner
    import led_frame_scanner_pkg::*;
#(
    parameter int p_frequency  = 50_000_000,
    parameter int p_row_num    = 8,
    parameter int p_column_num = 8,
    parameter int p_refresh_hz = 100
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_enable,
    input  logic                                i_wr_en,
    input  logic [$clog2(p_row_num)-1:0]        i_wr_row,
    input  logic [p_column_num-1:0]             i_wr_data,
    input  logic                                i_swap_req,
    output logic                                o_swap_pending,
    output logic                                o_start,
    output logic [8+p_row_num+p_column_num-1:0] o_instruction,
    output logic                                o_frame_tick
);

    localparam int ROW_DWELL = calc_row_dwell(p_frequency, p_refresh_hz, p_row_num);
    localparam int ROW_W     = $clog2(p_row_num);
    localparam int CNT_W     = $clog2(ROW_DWELL);
    localparam int INSTR_W   = 8 + p_row_num + p_column_num;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(p_row_num - 1);

    generate
        if (ROW_DWELL < 4) begin : g_dwell_check
            $error("led_frame_scanner: ROW_DWELL must be at least 4 cycles");
        end
    endgenerate

    scan_state_e              r_state;
    scan_state_e              w_state_nxt;
    logic [ROW_W-1:0]         r_row_idx;
    logic [ROW_W-1:0]         w_row_nxt;
    logic [ROW_W-1:0]         w_row_inc;
    logic [CNT_W-1:0]         r_dwell_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_slot_end;
    logic                     w_wrap;
    logic                     w_swap_apply;
    logic                     w_pending_nxt;
    logic                     r_swap_pending;
    logic                     w_start_nxt;
    logic                     r_start;
    logic [INSTR_W-1:0]       w_instr_nxt;
    logic [INSTR_W-1:0]       r_instruction;
    logic                     r_frame_tick;
    logic [p_row_num-1:0]     w_row_onehot;
    logic [p_column_num-1:0]  w_front_row;

    assign w_row_onehot = {{(p_row_num-1){1'b0}}, 1'b1} << r_row_idx;
    assign w_row_inc    = (r_row_idx == ROW_LAST) ? '0 : r_row_idx + 1'b1;

    led_frame_bank #(
        .p_row_num    (p_row_num),
        .p_column_num (p_column_num)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_row  (i_wr_row),
        .i_wr_data (i_wr_data),
        .i_swap    (w_swap_apply),
        .i_rd_row  (r_row_idx),
        .o_rd_data (w_front_row)
    );

    // Scan FSM next-state, counters and the output values to register
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_idx;
        w_cnt_nxt   = r_dwell_cnt;
        w_slot_end  = 1'b0;
        w_wrap      = 1'b0;
        w_start_nxt = 1'b0;
        w_instr_nxt = r_instruction;
        case (r_state)
            ST_IDLE: begin
                w_instr_nxt = '0;
                w_row_nxt   = '0;
                w_cnt_nxt   = '0;
                if (i_enable) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_start_nxt = 1'b1;
                w_instr_nxt = {MODE_RS_PIC, w_row_onehot, w_front_row};
                w_cnt_nxt   = '0;
                w_state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
                if (r_dwell_cnt == DWELL_LAST) begin
                    w_cnt_nxt = '0;
`ifdef LED_SCAN_BLANK_EN
                    w_state_nxt = ST_BLANK;
`else
                    w_slot_end = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_dwell_cnt + 1'b1;
                end
            end
`ifdef LED_SCAN_BLANK_EN
            ST_BLANK: begin
                // First blank cycle sends an all-off instruction to flush ghosting
                if (r_dwell_cnt == '0) begin
                    w_start_nxt = 1'b1;
                    w_instr_nxt = {MODE_RS_PIC, {(p_row_num+p_column_num){1'b0}}};
                end else begin
                    w_start_nxt = 1'b0;
                end
                if (r_dwell_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    w_slot_end = 1'b1;
                end else begin
                    w_cnt_nxt = r_dwell_cnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        // End of a full row slot: advance or retire, and flag the frame wrap
        if (w_slot_end) begin
            w_cnt_nxt = '0;
            w_wrap    = (r_row_idx == ROW_LAST);
            if (i_enable) begin
                w_state_nxt = ST_ISSUE;
                w_row_nxt   = w_row_inc;
            end else begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = '0;
            end
        end else begin
            w_wrap = 1'b0;
        end
    end

    // Swap is applied on a frame wrap, or straight away while idle; a new request re-arms
    always_comb begin
        w_swap_apply = r_swap_pending & (w_wrap | (r_state == ST_IDLE));
        if (i_swap_req) begin
            w_pending_nxt = 1'b1;
        end else if (w_swap_apply) begin
            w_pending_nxt = 1'b0;
        end else begin
            w_pending_nxt = r_swap_pending;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row/dwell counters, swap flag and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_idx      <= '0;
            r_dwell_cnt    <= '0;
            r_swap_pending <= 1'b0;
            r_start        <= 1'b0;
            r_instruction  <= '0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_row_idx      <= w_row_nxt;
            r_dwell_cnt    <= w_cnt_nxt;
            r_swap_pending <= w_pending_nxt;
            r_start        <= w_start_nxt;
            r_instruction  <= w_instr_nxt;
            r_frame_tick   <= w_wrap;
        end
    end

    assign o_swap_pending = r_swap_pending;
    assign o_start        = r_start;
    assign o_instruction  = r_instruction;
    assign o_frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_led_frame_scanner.sv
// Self-checking bench for led_frame_scanner: directed scenarios plus random
// host traffic, checked every cycle against a slot-phase reference model.
module tb_led_frame_scanner;
    import led_frame_scanner_pkg::*;

    localparam int ROW_DWELL = 10;
`ifdef LED_SCAN_BLANK_EN
    localparam int PERIOD = ROW_DWELL + 4;
`else
    localparam int PERIOD = ROW_DWELL;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_row = 3'd0;
    logic [7:0]  i_wr_data = 8'd0;
    logic        i_swap_req = 1'b0;
    logic        o_swap_pending;
    logic        o_start;
    logic [23:0] o_instruction;
    logic        o_frame_tick;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: position within the slot (-1 = idle), current row, banks
    int          m_pos;
    int          m_row;
    logic [7:0]  m_bank [2][8];
    int          m_front;
    bit          m_pending;
    logic        e_start;
    logic        e_tick;
    logic [23:0] e_instr;

    led_frame_scanner #(
        .p_frequency  (8000),
        .p_row_num    (8),
        .p_column_num (8),
        .p_refresh_hz (100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_wr_en        (i_wr_en),
        .i_wr_row       (i_wr_row),
        .i_wr_data      (i_wr_data),
        .i_swap_req     (i_swap_req),
        .o_swap_pending (o_swap_pending),
        .o_start        (o_start),
        .o_instruction  (o_instruction),
        .o_frame_tick   (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1;
        m_row = 0;
        m_front = 0;
        m_pending = 1'b0;
        e_start = 1'b0;
        e_tick = 1'b0;
        e_instr = 24'h0;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
                m_bank[b][r] = 8'h00;
            end
        end
    endtask

    // One clock: predict from current inputs, clock the DUT, compare at the falling edge
    task automatic cyc();
        int  pos_n;
        int  row_n;
        bit  wrap;
        bit  apply;
        int  back;
        pos_n = m_pos;
        row_n = m_row;
        wrap = 1'b0;
        if (m_pos < 0) begin
            if (i_enable) begin
                pos_n = PERIOD - 1;
                row_n = 0;
            end
        end else if (m_pos == PERIOD - 2) begin
            wrap = (m_row == 7);
            if (i_enable) begin
                pos_n = PERIOD - 1;
                row_n = (m_row + 1) % 8;
            end else begin
                pos_n = -1;
                row_n = 0;
            end
        end else begin
            pos_n = (m_pos + 1) % PERIOD;
        end
        if (m_pos < 0) begin
            e_instr = 24'h0;
        end else if (m_pos == PERIOD - 1) begin
            e_instr = {MODE_RS_PIC, 8'(1 << m_row), m_bank[m_front][m_row]};
        end
`ifdef LED_SCAN_BLANK_EN
        else if (m_pos == ROW_DWELL - 1) begin
            e_instr = {MODE_RS_PIC, 16'h0000};
        end
        e_start = (pos_n == 0) || (pos_n == ROW_DWELL);
`else
        e_start = (pos_n == 0);
`endif
        e_tick = wrap;
        apply = m_pending && (wrap || (m_pos < 0));
        back = 1 - m_front;
        if (i_wr_en) m_bank[back][i_wr_row] = i_wr_data;
        if (apply) m_front = back;
        m_pending = i_swap_req ? 1'b1 : (apply ? 1'b0 : m_pending);
        m_pos = pos_n;
        m_row = row_n;
        @(posedge clk);
        @(negedge clk);
        check("start", 32'(o_start), 32'(e_start));
        check("instr", 32'(o_instruction), 32'(e_instr));
        check("tick", 32'(o_frame_tick), 32'(e_tick));
        check("pending", 32'(o_swap_pending), 32'(m_pending));
    endtask

    task automatic wait_start(input string tag, input int bound, output int n);
        for (n = 1; n <= bound; n++) begin
            cyc();
            if (o_start === 1'b1) return;
        end
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed no start expected start within %0d cycles", tag, bound);
    endtask

    initial begin
        int  n;
        bit  saw_tick;
        model_reset();
        #12;
        check("rst_start", 32'(o_start), 32'd0);
        check("rst_instr", 32'(o_instruction), 32'd0);
        check("rst_tick", 32'(o_frame_tick), 32'd0);
        check("rst_pending", 32'(o_swap_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // First start two cycles after enable, then fixed spacing
        i_enable = 1'b1;
        wait_start("first_start", 20, n);
        check("first_latency", 32'(n), 32'd2);
        check("first_instr", 32'(o_instruction), 32'({MODE_RS_PIC, 8'h01, 8'h00}));
        wait_start("second_start", 40, n);
        check("start_spacing", 32'(n), 32'(PERIOD));

        // Fill back bank with A5 and request a swap mid-frame
        for (int r = 0; r < 8; r++) begin
            i_wr_en = 1'b1;
            i_wr_row = 3'(r);
            i_wr_data = 8'hA5;
            cyc();
        end
        i_wr_en = 1'b0;
        i_swap_req = 1'b1;
        cyc();
        i_swap_req = 1'b0;
        check("swap_pending_set", 32'(o_swap_pending), 32'd1);
        saw_tick = 1'b0;
        for (int k = 0; k < 200 && !saw_tick; k++) begin
            cyc();
            saw_tick = o_frame_tick;
        end
        check("swap_tick_seen", 32'(saw_tick), 32'd1);
        check("swap_pending_clr", 32'(o_swap_pending), 32'd0);
        wait_start("swap_row0", 20, n);
        check("swap_row0_instr", 32'(o_instruction), 32'({MODE_RS_PIC, 8'h01, 8'hA5}));

        // Drop enable at dwell count 3 of row 5
        for (int k = 0; k < 12; k++) begin
            wait_start("find_row5", 40, n);
            if (o_instruction[15:8] == 8'h20) break;
        end
        check("row5_found", 32'(o_instruction[15:8]), 32'h20);
        cyc();
        cyc();
        cyc();
        i_enable = 1'b0;
        saw_tick = 1'b0;
        for (int k = 0; k < PERIOD + 4; k++) begin
            cyc();
            saw_tick = saw_tick | o_frame_tick;
        end
        check("drop_no_tick", 32'(saw_tick), 32'd0);
        check("drop_idle_instr", 32'(o_instruction), 32'd0);
        i_enable = 1'b1;
        wait_start("reenable", 20, n);
        check("reenable_row0", 32'(o_instruction[15:8]), 32'h01);

        // Write row 2 in the very cycle the swap applies
        i_swap_req = 1'b1;
        cyc();
        i_swap_req = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_pos == PERIOD - 2 && m_row == 7) break;
            cyc();
        end
        i_wr_en = 1'b1;
        i_wr_row = 3'd2;
        i_wr_data = 8'h3C;
        cyc();
        i_wr_en = 1'b0;
        check("coinc_pending_clr", 32'(o_swap_pending), 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_start("find_row2", 40, n);
            if (o_instruction[15:8] == 8'h04) break;
        end
        check("coinc_row2", 32'(o_instruction), 32'({MODE_RS_PIC, 8'h04, 8'h3C}));

        // Random host traffic with occasional enable toggles
        for (int k = 0; k < 600; k++) begin
            i_wr_en = ($urandom_range(0, 3) == 0);
            i_wr_row = 3'($urandom_range(0, 7));
            i_wr_data = 8'($urandom);
            i_swap_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 79) == 0) i_enable = ~i_enable;
            cyc();
        end
        i_wr_en = 1'b0;
        i_swap_req = 1'b0;
        i_enable = 1'b1;

        // Asynchronous reset in the middle of a dwell
        wait_start("pre_reset", 60, n);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", 32'(o_start), 32'd0);
        check("arst_instr", 32'(o_instruction), 32'd0);
        check("arst_tick", 32'(o_frame_tick), 32'd0);
        check("arst_pending", 32'(o_swap_pending), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start("post_reset", 20, n);
        check("post_reset_instr", 32'(o_instruction), 32'({MODE_RS_PIC, 8'h01, 8'h00}));
        for (int k = 0; k < PERIOD * 9; k++) begin
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
